// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared widths and FSM encoding for the VRAM arbiter.
package vram_arb_pkg;
    localparam int DMA_ADDR_W = 16;
    localparam int DATA_W     = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_ADDR,
        ST_WAIT,
        ST_ACK,
        ST_REL,
        ST_SLOT
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder; the first request at or
// after ptr_i (wrapping) wins.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    logic [IW-1:0] j;
    // Walk from the farthest offset back to the pointer so the nearest request wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % NREQ);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the 64K video/system RAM between the CPU and NREQ DMA
// read requesters, stalling the CPU via cpu_hold and rotating DMA ownership.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int HOLD_SETUP = 1,
    parameter int MEM_LAT    = 1,
    parameter int MAX_BURST  = 16,
    parameter int CPU_SLOT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DMA_ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]            cpu_dout,
    input  logic                         cpu_rw,
    input  logic                         cpu_vma,
    output logic                         cpu_hold,
    output logic [DATA_W-1:0]            cpu_din,
    input  logic [NREQ-1:0]              dma_req,
    input  logic [DMA_ADDR_W*NREQ-1:0]   dma_addr,
    output logic [NREQ-1:0]              dma_gnt,
    output logic [NREQ-1:0]              dma_ack,
    output logic [DATA_W-1:0]            dma_rdata,
    output logic [DMA_ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]            mem_dout,
    input  logic [DATA_W-1:0]            mem_din,
    output logic                         mem_cs,
    output logic                         mem_we
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LMAX = (HOLD_SETUP > MEM_LAT) ? HOLD_SETUP : MEM_LAT;
    localparam int LW   = (LMAX > 0) ? $clog2(LMAX + 1) : 1;
    localparam int SW   = $clog2(CPU_SLOT + 1);

    state_t            st_q, st_d;
    logic [IW-1:0]     w_q, w_d, rr_q, rr_d, rr_nxt, pick_ptr, pick_idx;
    logic [NREQ-1:0]   gnt_q, gnt_d, pick_gnt;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        burst_q, burst_d, burst_inc;
    logic [LW-1:0]     lat_q, lat_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              pick_any, dma_own;
    logic [DMA_ADDR_W-1:0] addr_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_addr
        assign addr_a[g] = dma_addr[g*DMA_ADDR_W +: DMA_ADDR_W];
    end

    // In REL the pointer has not been written yet, so arbitrate with its next value.
    assign rr_nxt    = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
    assign pick_ptr  = (st_q == ST_REL) ? rr_nxt : rr_q;
    assign burst_inc = (burst_q == 8'(MAX_BURST)) ? burst_q : burst_q + 8'd1;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (dma_req),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        st_d    = st_q;
        w_d     = w_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        burst_d = burst_q;
        lat_d   = lat_q;
        slot_d  = slot_q;
        case (st_q)
            ST_IDLE: if (pick_any) begin
                st_d  = ST_HOLD;
                w_d   = pick_idx;
                gnt_d = pick_gnt;
                lat_d = '0;
            end
            ST_HOLD: begin
                st_d  = (lat_q == LW'(HOLD_SETUP)) ? ST_ADDR : ST_HOLD;
                lat_d = (lat_q == LW'(HOLD_SETUP)) ? lat_q : lat_q + 1'b1;
            end
            ST_ADDR: begin
                st_d  = ST_WAIT;
                lat_d = LW'(1);
            end
            ST_WAIT: if (lat_q == LW'(MEM_LAT)) begin
                st_d    = ST_ACK;
                rdata_d = mem_din;
            end else begin
                lat_d = lat_q + 1'b1;
            end
            ST_ACK: begin
                burst_d = burst_inc;
                st_d    = (dma_req[w_q] && burst_inc < 8'(MAX_BURST)) ? ST_ADDR : ST_REL;
            end
            ST_REL: begin
                burst_d = '0;
                rr_d    = rr_nxt;
                gnt_d   = '0;
                if (burst_q == 8'(MAX_BURST) && cpu_vma) begin
                    st_d   = ST_SLOT;
                    slot_d = SW'(1);
                end else if (pick_any) begin
                    st_d  = ST_HOLD;
                    w_d   = pick_idx;
                    gnt_d = pick_gnt;
                    lat_d = LW'(HOLD_SETUP);
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_SLOT: begin
                st_d   = (slot_q == SW'(CPU_SLOT)) ? ST_IDLE : ST_SLOT;
                slot_d = slot_q + 1'b1;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q    <= ST_IDLE;
            w_q     <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            rdata_q <= '0;
            burst_q <= '0;
            lat_q   <= '0;
            slot_q  <= '0;
        end else begin
            st_q    <= st_d;
            w_q     <= w_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            burst_q <= burst_d;
            lat_q   <= lat_d;
            slot_q  <= slot_d;
        end
    end

    assign dma_own   = st_q inside {ST_HOLD, ST_ADDR, ST_WAIT, ST_ACK, ST_REL};
    assign cpu_hold  = dma_own;
    assign cpu_din   = mem_din;
    assign mem_dout  = cpu_dout;
    assign mem_addr  = dma_own ? addr_a[w_q] : cpu_addr;
    assign mem_cs    = dma_own ? (st_q == ST_ADDR || st_q == ST_WAIT) : cpu_vma;
    assign mem_we    = ~dma_own & cpu_vma & ~cpu_rw;
    assign dma_gnt   = gnt_q;
    assign dma_ack   = (st_q == ST_ACK) ? gnt_q : '0;
    assign dma_rdata = rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios for vram_arbiter against a RAM model
// whose untouched contents follow pat(addr).
module tb_vram_arbiter;
    localparam int NREQ = 2;
    localparam int HOLD_SETUP = 1;
    localparam int MEM_LAT = 1;
    localparam int MAX_BURST = 16;
    localparam int CPU_SLOT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_vma;
    logic        cpu_hold;
    logic [7:0]  cpu_din;
    logic [1:0]  dma_req;
    logic [31:0] dma_addr;
    logic [1:0]  dma_gnt;
    logic [1:0]  dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_cs;
    logic        mem_we;

    int errors = 0;
    int checks = 0;

    vram_arbiter #(
        .NREQ(NREQ), .HOLD_SETUP(HOLD_SETUP), .MEM_LAT(MEM_LAT),
        .MAX_BURST(MAX_BURST), .CPU_SLOT(CPU_SLOT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
        .cpu_hold(cpu_hold), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_cs(mem_cs), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // One-cycle-latency RAM: pattern contents plus one remembered CPU write.
    logic        wvalid = 1'b0;
    logic [15:0] waddr = 16'h0;
    logic [7:0]  wdata = 8'h0;
    always @(posedge clk) begin
        if (mem_we) begin
            wvalid <= 1'b1;
            waddr  <= mem_addr;
            wdata  <= mem_dout;
        end
        mem_din <= (wvalid && waddr == mem_addr) ? wdata : pat(mem_addr);
    end

    task automatic test_reset();
        rst = 1'b0; cpu_vma = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0; cpu_dout = 8'h0;
        dma_req = 2'b11; dma_addr = {16'h4000, 16'h3000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_hold !== 1'b0 || dma_gnt !== 2'b00 || mem_cs !== 1'b0 || dma_ack !== 2'b00 || dma_rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d: hold=%b gnt=%b cs=%b ack=%b rdata=%h, want 0 00 0 00 00",
                         k, cpu_hold, dma_gnt, mem_cs, dma_ack, dma_rdata);
            end
        end
        dma_req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, a1, ea;
        logic drop0, drop1;
        int w0, w1, n, last, r, b;
        a0 = 16'h3000; a1 = 16'h4000; drop0 = 1'b0; drop1 = 1'b0;
        w0 = 0; w1 = 0; n = 0; last = 0;
        dma_addr = {a1, a0};
        dma_req = 2'b11;
        for (int cyc = 1; cyc <= 200 && n < 12; cyc++) begin
            @(negedge clk);
            if (drop0) begin dma_req[0] = 1'b1; drop0 = 1'b0; end
            if (drop1) begin dma_req[1] = 1'b1; drop1 = 1'b0; end
            if (dma_ack != 2'b00) begin
                b = n / 3;
                r = b % 2;
                ea = (r == 0 ? 16'h3000 : 16'h4000) + 16'((b / 2) * 3 + n % 3);
                checks++;
                if (dma_ack !== 2'(1 << r) || dma_gnt !== 2'(1 << r)) begin
                    errors++;
                    $display("FAIL rr_order ack#%0d: ack=%b gnt=%b, want %b", n, dma_ack, dma_gnt, 2'(1 << r));
                end
                checks++;
                if (dma_rdata !== pat(ea)) begin
                    errors++;
                    $display("FAIL rr_data ack#%0d: rdata=%h, want %h (addr %h)", n, dma_rdata, pat(ea), ea);
                end
                checks++;
                if (cyc - last != ((n % 3 == 0) ? 5 : 3)) begin
                    errors++;
                    $display("FAIL rr_spacing ack#%0d: gap=%0d, want %0d", n, cyc - last, (n % 3 == 0) ? 5 : 3);
                end
                last = cyc;
                n++;
                if (dma_ack[0]) begin
                    a0++; w0++;
                    if (w0 == 3) begin w0 = 0; dma_req[0] = 1'b0; drop0 = 1'b1; end
                end
                if (dma_ack[1]) begin
                    a1++; w1++;
                    if (w1 == 3) begin w1 = 0; dma_req[1] = 1'b0; drop1 = 1'b1; end
                end
                dma_addr = {a1, a0};
            end
        end
        dma_req = 2'b00;
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL rr_count: acks=%0d, want 12", n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || dma_gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle: hold=%b gnt=%b, want 0 00", cpu_hold, dma_gnt);
        end
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_vma = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1234; cpu_dout = 8'h5A;
        #1;
        checks++;
        if ({mem_we, mem_cs, mem_addr, mem_dout, cpu_hold} !== {1'b1, 1'b1, 16'h1234, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL cpu_write: we=%b cs=%b addr=%h dout=%h hold=%b, want 1 1 1234 5a 0",
                     mem_we, mem_cs, mem_addr, mem_dout, cpu_hold);
        end
        @(negedge clk);
        cpu_rw = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_cs, cpu_hold} !== 3'b010) begin
            errors++;
            $display("FAIL cpu_read_cyc: we=%b cs=%b hold=%b, want 0 1 0", mem_we, mem_cs, cpu_hold);
        end
        @(negedge clk);
        cpu_addr = 16'h0042;
        #1;
        checks++;
        if (cpu_din !== 8'h5A || mem_we !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL cpu_readback: din=%h we=%b hold=%b, want 5a 0 0", cpu_din, mem_we, cpu_hold);
        end
        @(negedge clk);
        cpu_vma = 1'b0;
        #1;
        checks++;
        if (cpu_din !== pat(16'h0042) || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_fresh: din=%h hold=%b, want %h 0", cpu_din, cpu_hold, pat(16'h0042));
        end
    endtask

    task automatic test_single();
        logic [6:0] obs, exp;
        @(negedge clk);
        cpu_vma = 1'b0;
        dma_addr = {16'h0000, 16'h2000};
        dma_req = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            obs = {cpu_hold, mem_cs, mem_we, dma_ack, dma_gnt};
            exp = {k <= 6, k == 3 || k == 4, 1'b0, k == 5 ? 2'b01 : 2'b00, k <= 6 ? 2'b01 : 2'b00};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single cyc%0d: hold,cs,we,ack,gnt=%b, want %b", k, obs, exp);
            end
            if (k == 3) begin
                checks++;
                if (mem_addr !== 16'h2000) begin
                    errors++;
                    $display("FAIL single_addr: mem_addr=%h, want 2000", mem_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (dma_rdata !== pat(16'h2000)) begin
                    errors++;
                    $display("FAIL single_data: rdata=%h, want %h", dma_rdata, pat(16'h2000));
                end
                dma_req = 2'b00;
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [15:0] a0;
        logic seen, got;
        int n, lowc;
        a0 = 16'h5000; n = 0; seen = 1'b0; got = 1'b0; lowc = 1;
        @(negedge clk);
        cpu_vma = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0100;
        dma_addr = {16'h0000, a0};
        dma_req = 2'b01;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk);
            if (cpu_hold) seen = 1'b1;
            else if (seen) break;
            if (dma_ack[0]) begin
                checks++;
                if (dma_rdata !== pat(a0)) begin
                    errors++;
                    $display("FAIL cap_data ack#%0d: rdata=%h, want %h", n, dma_rdata, pat(a0));
                end
                a0++; n++;
                dma_addr[15:0] = a0;
            end
        end
        checks++;
        if (n != MAX_BURST) begin
            errors++;
            $display("FAIL cap_count: acks=%0d, want %0d", n, MAX_BURST);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cpu_hold) break;
            lowc++;
            checks++;
            if (dma_gnt !== 2'b00 || mem_cs !== 1'b1 || mem_addr !== 16'h0100) begin
                errors++;
                $display("FAIL cap_slot_bus: gnt=%b cs=%b addr=%h, want 00 1 0100", dma_gnt, mem_cs, mem_addr);
            end
        end
        // CPU_SLOT cycles plus the IDLE cycle in which the pending request is re-arbitrated.
        checks++;
        if (lowc != CPU_SLOT + 1) begin
            errors++;
            $display("FAIL cap_slot_len: hold low %0d cycles, want %0d", lowc, CPU_SLOT + 1);
        end
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (dma_ack[0]) begin
                got = 1'b1;
                checks++;
                if (dma_rdata !== pat(16'h5010)) begin
                    errors++;
                    $display("FAIL cap_resume: rdata=%h, want %h", dma_rdata, pat(16'h5010));
                end
                dma_req = 2'b00;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cap_resume_timeout: ack seen=%b, want 1", got);
        end
        cpu_vma = 1'b0;
        dma_req = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL cap_idle: hold=%b, want 0", cpu_hold);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs, exp;
        @(negedge clk);
        cpu_vma = 1'b0;
        dma_addr = {16'h0000, 16'h6000};
        dma_req = 2'b01;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1 || mem_addr !== 16'h6000 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL midrst_wait: cs=%b addr=%h hold=%b, want 1 6000 1", mem_cs, mem_addr, cpu_hold);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({cpu_hold, dma_gnt, dma_ack, mem_cs, dma_rdata} !== 14'h0) begin
                errors++;
                $display("FAIL midrst_out cyc%0d: hold=%b gnt=%b ack=%b cs=%b rdata=%h, want all 0",
                         k, cpu_hold, dma_gnt, dma_ack, mem_cs, dma_rdata);
            end
        end
        rst = 1'b1;
        dma_addr = {16'h0000, 16'h6100};
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            obs = {cpu_hold, mem_cs, mem_we, dma_ack, dma_gnt};
            exp = {k <= 6, k == 3 || k == 4, 1'b0, k == 5 ? 2'b01 : 2'b00, k <= 6 ? 2'b01 : 2'b00};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_fresh cyc%0d: hold,cs,we,ack,gnt=%b, want %b", k, obs, exp);
            end
            if (k == 5) begin
                checks++;
                if (dma_rdata !== pat(16'h6100)) begin
                    errors++;
                    $display("FAIL midrst_data: rdata=%h, want %h", dma_rdata, pat(16'h6100));
                end
                dma_req = 2'b00;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_cpu_only();
        test_single();
        test_burst_cap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
